// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//   Multi-cycle integer divide sequencer for the EXU. It uses radix-2 restoring
//   division and produces one quotient bit per clock. It covers
//   DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW. Both sides use a
//   valid/ready handshake, so the pipeline stalls on in_ready/out_valid.
//
//   Divide-by-zero and signed overflow finish in the accept cycle, so they skip
//   the iteration.
//
//   Normal ops take these phases:
//     accept -> CALC (one iteration per cycle, 64 or 32 cycles) -> FIX -> DONE
//
// Ports
//   clock      in   1     rising-edge clock
//   reset_n    in   1     asynchronous reset, active low
//   in_valid   in   1     request valid
//   in_ready   out  1     idle, can accept a request
//   data_a     in   XLEN  dividend
//   data_b     in   XLEN  divisor
//   is_signed  in   1     1 = signed (DIV/REM), 0 = unsigned
//   is_rem     in   1     1 = return remainder, 0 = return quotient
//   is_word    in   1     1 = 32-bit op on low half, result sign-extended
//   flush      in   1     kill in-flight op / block accept (highest priority)
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts result
//   result     out  XLEN  quotient or remainder
//   busy       out  1     not idle (hazard unit)
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] ONE_X = XLEN'(1);
  localparam logic [HALF-1:0] ONE_H = HALF'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] b_abs_reg;
  logic [CW-1:0]   cnt_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            rem_sel_reg;
  logic            word_reg;
  logic [XLEN-1:0] result_reg;

  // ---------------------------------------------------------------------------
  // Request decode.
  // Word ops look only at the low half of each operand. This applies to every
  // check: zero, overflow and sign.
  // ---------------------------------------------------------------------------
  logic            a_sign, b_sign;
  logic [HALF-1:0] a_neg_w, b_neg_w;
  logic [XLEN-1:0] a_neg_d, b_neg_d;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] a_sext_w;
  logic            b_zero, a_min, b_neg1, ovf;
  logic            accept, special;
  logic [XLEN-1:0] special_res;

  assign a_sign = is_signed & (is_word ? data_a[HALF-1] : data_a[XLEN-1]);
  assign b_sign = is_signed & (is_word ? data_b[HALF-1] : data_b[XLEN-1]);

  assign a_neg_w = ~data_a[HALF-1:0] + ONE_H;
  assign b_neg_w = ~data_b[HALF-1:0] + ONE_H;
  assign a_neg_d = ~data_a + ONE_X;
  assign b_neg_d = ~data_b + ONE_X;

  // Magnitudes are zero-extended to XLEN. The most-negative value maps to
  // 2^(w-1), and that still fits as an unsigned w-bit number.
  always_comb begin
    a_abs = '0;
    b_abs = '0;
    if (is_word) begin
      a_abs[HALF-1:0] = a_sign ? a_neg_w : data_a[HALF-1:0];
      b_abs[HALF-1:0] = b_sign ? b_neg_w : data_b[HALF-1:0];
    end else begin
      a_abs = a_sign ? a_neg_d : data_a;
      b_abs = b_sign ? b_neg_d : data_b;
    end
  end

  assign a_sext_w = {{HALF{data_a[HALF-1]}}, data_a[HALF-1:0]};

  assign b_zero = is_word ? (data_b[HALF-1:0] == '0) : (data_b == '0);
  assign a_min  = is_word ? (data_a[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                          : (data_a == {1'b1, {(XLEN-1){1'b0}}});
  assign b_neg1 = is_word ? (data_b[HALF-1:0] == '1) : (data_b == '1);
  assign ovf    = is_signed & a_min & b_neg1;

  assign accept  = (state_reg == S_IDLE) & in_valid & ~flush;
  assign special = b_zero | ovf;

  // Divide-by-zero: quotient is all ones and the remainder is the dividend.
  // Overflow: quotient is the dividend and the remainder is zero.
  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = is_rem ? (is_word ? a_sext_w : data_a) : '1;
    end else if (!is_rem) begin
      special_res = is_word ? a_sext_w : data_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring step. {rem,quo} shifts left and the next dividend bit enters
  // rem from the top of quo. The shifted remainder can need XLEN+1 bits, so the
  // compare uses that width. When the trial succeeds the true difference is
  // below 2^XLEN, so a wrapping XLEN-bit subtract gives the exact value.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_sh;
  logic            trial_ok;
  logic [XLEN-1:0] rem_trial;

  assign rem_sh    = {rem_reg, quo_reg[XLEN-1]};
  assign trial_ok  = rem_sh >= {1'b0, b_abs_reg};
  assign rem_trial = rem_sh[XLEN-1:0] - b_abs_reg;

  // Sign fix-up and result formatting.
  logic [XLEN-1:0] q_fix, r_fix, sel_fix, res_fix;

  assign q_fix   = neg_q_reg ? (~quo_reg + ONE_X) : quo_reg;
  assign r_fix   = neg_r_reg ? (~rem_reg + ONE_X) : rem_reg;
  assign sel_fix = rem_sel_reg ? r_fix : q_fix;
  assign res_fix = word_reg ? {{HALF{sel_fix[HALF-1]}}, sel_fix[HALF-1:0]} : sel_fix;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. flush wins over everything, including a same-cycle accept
  // or out_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE: if (in_valid) state_next = special ? S_DONE : S_CALC;
        S_CALC: if (cnt_reg == CW'(1)) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
    busy      = (state_reg != S_IDLE);
  end

  assign result = result_reg;

  // ---------------------------------------------------------------------------
  // Datapath. Operands and flags are latched at accept, so later input changes
  // have no effect. A flush leaves result_reg holding its previous value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_reg     <= '0;
      rem_reg     <= '0;
      b_abs_reg   <= '0;
      cnt_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
      word_reg    <= 1'b0;
      result_reg  <= '0;
    end else begin
      if (accept) begin
        if (special) begin
          result_reg <= special_res;
        end else begin
          // Word dividends are pre-shifted to the top so that the top bit
          // shifted out of quo is always the next dividend bit.
          quo_reg     <= is_word ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
          rem_reg     <= '0;
          b_abs_reg   <= b_abs;
          cnt_reg     <= is_word ? CW'(HALF) : CW'(XLEN);
          neg_q_reg   <= a_sign ^ b_sign;
          neg_r_reg   <= a_sign;
          rem_sel_reg <= is_rem;
          word_reg    <= is_word;
        end
      end else if (state_reg == S_CALC && !flush) begin
        rem_reg <= trial_ok ? rem_trial : rem_sh[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], trial_ok};
        cnt_reg <= cnt_reg - CW'(1);
      end else if (state_reg == S_FIX && !flush) begin
        result_reg <= res_fix;
      end
    end
  end

endmodule
